pipe_frame_ctrl: RTL and testbench
==================================

// Module: pipe_frame_ctrl
// PURPOSE
//  Per-frame sequencer for the stereo pipeline wrapper. On start it latches the 4x32b pipe config words,
//  holds the pipe in sync reset for a fixed flush period, then admits exactly cfg_in_tokens input beats.
//  It completes the frame once cfg_out_tokens output beats have been delivered downstream.
//  Sits between the DMA/stream side and hsfn, and replaces the ad-hoc start->sync_reset register.
// PARAMETERS
//  RESET_CYCLES   4        cycles pipe_reset is held in FLUSH (>=1)
//  CNT_W          32       width of token counters and config counts
//  TIMEOUT_CYCLES 1048576  idle-handshake cycles before abort (only with PIPE_FRAME_CTRL_TIMEOUT_EN)
// PORTS
//  clk            in   1      clock
//  reset          in   1      synchronous, active-high
//  start          in   1      frame start pulse; honoured only in IDLE
//  cfg_in_tokens  in   CNT_W  input beats per frame
//  cfg_out_tokens in   CNT_W  output beats per frame
//  mmio_in        in   128    {PIPE3,PIPE2,PIPE1,PIPE0}, sampled on accepted start
//  mmio_lat       out  128    latched config to pipe; stable for the whole frame
//  in_valid       in   1      upstream valid
//  in_ready       out  1      upstream ready (gated)
//  pipe_in_valid  out  1      valid to pipe (gated)
//  pipe_in_ready  in   1      pipe ready
//  pipe_out_valid in   1      pipe output valid
//  pipe_out_ready out  1      ready to pipe
//  out_valid      out  1      downstream valid
//  out_ready      in   1      downstream ready
//  pipe_reset     out  1      synchronous reset to pipe
//  busy           out  1      high in FLUSH/RUN/DRAIN
//  done           out  1      1-cycle pulse at frame end
//  err_timeout    out  1      sticky abort flag; cleared by next accepted start
//  in_count       out  CNT_W  input beats accepted this frame
//  out_count      out  CNT_W  output beats delivered this frame
// BEHAVIOUR
//  Reset: state=IDLE, pipe_reset=1, busy=0, done=0, err_timeout=0, counts=0, mmio_lat=0; all valids/readys 0.
//  States: IDLE -start-> FLUSH (RESET_CYCLES cycles) -> RUN -(in_count==cfg_in)-> DRAIN -(out_count==cfg_out)-> DONE -> IDLE.
//  Accepted start (cycle N): mmio_lat, cfg counts latched and counters cleared at edge N.
//   pipe_reset high cycles N+1..N+RESET_CYCLES; RUN from N+RESET_CYCLES+1.
//  pipe_reset=1 in IDLE, FLUSH, DONE; 0 in RUN, DRAIN. start outside IDLE is ignored (no queueing).
//  Input gate: adm = (state==RUN) && in_count<cfg_in.
//   pipe_in_valid = in_valid&&adm; in_ready = pipe_in_ready&&adm (combinational).
//  Output passthrough in RUN/DRAIN while out_count<cfg_out: out_valid=pipe_out_valid, pipe_out_ready=out_ready.
//   Otherwise both are 0.
//  Counters increment on each valid&&ready beat. When count==cfg, no further beats are admitted (no wrap).
//  RUN->DRAIN the cycle after the last input beat. RUN may go directly to DONE when both counts are met.
//  cfg_in_tokens=0: RUN lasts 1 cycle. cfg_out_tokens=0: DONE is reached without any output beat.
//  Input and output beats in the same cycle are both counted.
//  done asserts for exactly 1 cycle in DONE; busy is 0 in DONE.
//  Latency through the block is 0 cycles (pure gating); the pipe's own latency is unaffected.
//  reset mid-frame: immediate return to reset values; partial counts are discarded.
// CONFIGURATION
//  `PIPE_FRAME_CTRL_TIMEOUT_EN defined:
//   - Watchdog counts cycles in RUN/DRAIN with no input or output beat; it clears on any beat.
//   - Reaching TIMEOUT_CYCLES sets err_timeout and forces DONE (done pulses), aborting the frame.
//  Undefined: no watchdog logic; err_timeout tied 0; frame waits indefinitely.
// STRUCTURE
//  pipe_ctrl_pkg: state enum {IDLE,FLUSH,RUN,DRAIN,DONE}, MMIO_W=128, CNT_W default.
//  Sub-module beat_counter (clear, inc, limit -> count, at_limit), instantiated for input and output.
// TESTING
//  1 Reset, no start -> pipe_reset=1, in_ready=0, out_valid=0, busy=0 indefinitely.
//  2 start with cfg_in=16, cfg_out=8, RESET_CYCLES=4 -> pipe_reset high 4 cycles.
//    Then exactly 16 in beats and 8 out beats pass; done pulses once; in_count=16, out_count=8.
//  3 Upstream offers 20 beats with cfg_in=16 -> beats 17..20 stall (in_ready=0); no pipe_in_valid after 16th.
//  4 start pulsed during RUN -> ignored; mmio_lat unchanged; counts continue; single done.
//  5 cfg_in=0, cfg_out=0 -> FLUSH, 1-cycle RUN, DONE; done at start+RESET_CYCLES+2; no beats.
//  6 TIMEOUT_EN, TIMEOUT_CYCLES=64, pipe never outputs -> err_timeout=1 and done after 64 idle cycles.
//    Next start clears err_timeout.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the per-frame pipe sequencer.
//   frame_state_t : frame sequencer states IDLE, FLUSH, RUN, DRAIN, DONE
//   MMIO_W        : width of the latched pipe config bundle (4 x 32b words)
//   CNT_W_DEF     : default width of token counters and config counts
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } frame_state_t;

  localparam int MMIO_W    = 128;
  localparam int CNT_W_DEF = 32;

endpackage

// File: rtl/pipe_frame_ctrl_beat_counter.sv
// ---------------------------------------------------------------------------
// beat_counter
// Counts handshake beats up to a limit and saturates there (never wraps).
// Ports:
//   clk      in   clock
//   reset    in   synchronous active-high reset, clears the count
//   clear    in   synchronous clear (new frame)
//   inc      in   one beat this cycle
//   limit    in   W  beats allowed this frame
//   count    out  W  beats counted so far
//   at_limit out  count has reached limit (combinational from the count)
// ---------------------------------------------------------------------------
module beat_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         at_limit
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (inc && !at_limit) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign count    = count_reg;
  assign at_limit = (count_reg == limit);

endmodule

// File: rtl/pipe_frame_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_frame_ctrl
// Per-frame sequencer for the stereo pipeline wrapper. An accepted start
// latches the pipe config words and token counts, holds the pipe in reset for
// RESET_CYCLES, then admits exactly cfg_in_tokens input beats and passes
// output beats until cfg_out_tokens have been delivered. The handshakes are
// gated combinationally, so the block adds no latency.
//
// Optional feature: define PIPE_FRAME_CTRL_TIMEOUT_EN to build a watchdog that
// aborts a frame after TIMEOUT_CYCLES consecutive cycles without any beat in
// RUN/DRAIN (sets sticky err_timeout, still pulses done). Without the macro
// err_timeout is tied low and a frame waits indefinitely.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   start                       frame start pulse (honoured only in IDLE)
//   cfg_in_tokens/out_tokens    beats per frame, sampled on accepted start
//   mmio_in / mmio_lat          config words in / latched copy for the pipe
//   in_valid/in_ready           upstream handshake (ready gated)
//   pipe_in_valid/ready         handshake into the pipe (valid gated)
//   pipe_out_valid/ready        handshake out of the pipe (ready gated)
//   out_valid/out_ready         downstream handshake (valid gated)
//   pipe_reset                  synchronous reset to the pipe
//   busy, done, err_timeout     status: in frame, end pulse, abort flag
//   in_count, out_count         beats accepted / delivered this frame
// ---------------------------------------------------------------------------
module pipe_frame_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = 4,
  parameter int CNT_W        = CNT_W_DEF
`ifdef PIPE_FRAME_CTRL_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1048576
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_in_tokens,
  input  logic [CNT_W-1:0]  cfg_out_tokens,
  input  logic [MMIO_W-1:0] mmio_in,
  output logic [MMIO_W-1:0] mmio_lat,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              pipe_in_valid,
  input  logic              pipe_in_ready,
  input  logic              pipe_out_valid,
  output logic              pipe_out_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              pipe_reset,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic [CNT_W-1:0]  in_count,
  output logic [CNT_W-1:0]  out_count
);

  // Flush counter only needs to reach RESET_CYCLES-1.
  localparam int FLUSH_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(RESET_CYCLES - 1);

  frame_state_t        state_reg;
  logic [FLUSH_W-1:0]  flush_cnt_reg;
  logic [MMIO_W-1:0]   mmio_lat_reg;
  logic [CNT_W-1:0]    cfg_in_reg;
  logic [CNT_W-1:0]    cfg_out_reg;
  logic                pipe_reset_reg;
  logic                busy_reg;
  logic                done_reg;

  logic accept;
  logic active;
  logic adm;
  logic out_en;
  logic in_beat;
  logic out_beat;
  logic in_at_limit;
  logic out_at_limit;
  logic frame_met;
  logic abort;

  assign accept = (state_reg == IDLE) && start;
  assign active = (state_reg == RUN) || (state_reg == DRAIN);

  // Input is admitted only in RUN; once DRAIN is entered the input count is
  // already at its limit, so the RUN check alone is sufficient.
  assign adm    = (state_reg == RUN) && !in_at_limit;
  assign out_en = active && !out_at_limit;

  assign pipe_in_valid  = in_valid && adm;
  assign in_ready       = pipe_in_ready && adm;
  assign out_valid      = pipe_out_valid && out_en;
  assign pipe_out_ready = out_ready && out_en;

  assign in_beat  = in_valid && pipe_in_ready && adm;
  assign out_beat = pipe_out_valid && out_ready && out_en;

  // Completion looks at the registered counts, so the frame ends the cycle
  // after the last beat (or after one RUN cycle when both counts are zero).
  assign frame_met = in_at_limit && out_at_limit;

  beat_counter #(.W(CNT_W)) u_in_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept),
    .inc      (in_beat),
    .limit    (cfg_in_reg),
    .count    (in_count),
    .at_limit (in_at_limit)
  );

  beat_counter #(.W(CNT_W)) u_out_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept),
    .inc      (out_beat),
    .limit    (cfg_out_reg),
    .count    (out_count),
    .at_limit (out_at_limit)
  );

`ifdef PIPE_FRAME_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_reg;
  logic            err_reg;

  // Counts consecutive beat-free cycles while the frame is live.
  always_ff @(posedge clk) begin
    if (reset || !active || in_beat || out_beat) begin
      wd_reg <= '0;
    end else begin
      wd_reg <= wd_reg + WD_W'(1);
    end
  end

  // A normal completion in the same cycle wins over the watchdog.
  assign abort = active && !in_beat && !out_beat && (wd_reg == WD_LAST) && !frame_met;

  always_ff @(posedge clk) begin
    if (reset || accept) begin
      err_reg <= 1'b0;
    end else if (abort) begin
      err_reg <= 1'b1;
    end
  end

  assign err_timeout = err_reg;
`else
  assign abort       = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Frame sequencer; status outputs are written together with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      flush_cnt_reg  <= '0;
      mmio_lat_reg   <= '0;
      cfg_in_reg     <= '0;
      cfg_out_reg    <= '0;
      pipe_reset_reg <= 1'b1;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg     <= FLUSH;
            flush_cnt_reg <= '0;
            mmio_lat_reg  <= mmio_in;
            cfg_in_reg    <= cfg_in_tokens;
            cfg_out_reg   <= cfg_out_tokens;
            busy_reg      <= 1'b1;
          end
        end
        FLUSH: begin
          if (flush_cnt_reg == FLUSH_LAST) begin
            state_reg      <= RUN;
            pipe_reset_reg <= 1'b0;
          end else begin
            flush_cnt_reg <= flush_cnt_reg + FLUSH_W'(1);
          end
        end
        RUN, DRAIN: begin
          if (frame_met || abort) begin
            state_reg      <= DONE;
            pipe_reset_reg <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b1;
          end else if (in_at_limit) begin
            state_reg <= DRAIN;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg      <= IDLE;
          pipe_reset_reg <= 1'b1;
          busy_reg       <= 1'b0;
        end
      endcase
    end
  end

  assign mmio_lat   = mmio_lat_reg;
  assign pipe_reset = pipe_reset_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_pipe_frame_ctrl.sv
module tb_pipe_frame_ctrl;

  localparam int RC = 4;
  localparam int CW = 32;
`ifdef PIPE_FRAME_CTRL_TIMEOUT_EN
  localparam int TO = 64;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] cfg_in_tokens = '0;
  logic [CW-1:0] cfg_out_tokens = '0;
  logic [127:0]  mmio_in = '0;
  logic          in_valid = 1'b0;
  logic          pipe_in_ready = 1'b0;
  logic          pipe_out_valid = 1'b0;
  logic          out_ready = 1'b0;

  logic [127:0]  mmio_lat;
  logic          in_ready, pipe_in_valid, pipe_out_ready, out_valid;
  logic          pipe_reset, busy, done, err_timeout;
  logic [CW-1:0] in_count, out_count;

  int checks = 0;
  int errors = 0;

  // Reference state carried between frames.
  logic [127:0] mmio_exp = '0;
  int           in_exp = 0;
  int           out_exp = 0;
  bit           err_exp = 1'b0;

  pipe_frame_ctrl #(
    .RESET_CYCLES (RC),
    .CNT_W        (CW)
`ifdef PIPE_FRAME_CTRL_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (TO)
`endif
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .cfg_in_tokens  (cfg_in_tokens),
    .cfg_out_tokens (cfg_out_tokens),
    .mmio_in        (mmio_in),
    .mmio_lat       (mmio_lat),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .pipe_in_valid  (pipe_in_valid),
    .pipe_in_ready  (pipe_in_ready),
    .pipe_out_valid (pipe_out_valid),
    .pipe_out_ready (pipe_out_ready),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .pipe_reset     (pipe_reset),
    .busy           (busy),
    .done           (done),
    .err_timeout    (err_timeout),
    .in_count       (in_count),
    .out_count      (out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random handshake levels (percent probabilities) plus noise on the
  // config inputs, which must be ignored outside an accepted start.
  task automatic rand_inputs(input int p_in, input int p_pr, input int p_ov, input int p_or);
    in_valid       = ($urandom_range(99) < p_in);
    pipe_in_ready  = ($urandom_range(99) < p_pr);
    pipe_out_valid = ($urandom_range(99) < p_ov);
    out_ready      = ($urandom_range(99) < p_or);
    mmio_in        = {$urandom, $urandom, $urandom, $urandom};
    cfg_in_tokens  = $urandom_range(0, 40);
    cfg_out_tokens = $urandom_range(0, 40);
  endtask

  task automatic check_idle(input string tag);
    #1;
    chk({tag, ".pipe_reset"},     pipe_reset,     1'b1);
    chk({tag, ".in_ready"},       in_ready,       1'b0);
    chk({tag, ".pipe_in_valid"},  pipe_in_valid,  1'b0);
    chk({tag, ".out_valid"},      out_valid,      1'b0);
    chk({tag, ".pipe_out_ready"}, pipe_out_ready, 1'b0);
    chk({tag, ".busy"},           busy,           1'b0);
    chk({tag, ".done"},           done,           1'b0);
    chk({tag, ".in_count"},       in_count,       in_exp);
    chk({tag, ".out_count"},      out_count,      out_exp);
    chk({tag, ".mmio_lat"},       mmio_lat,       mmio_exp);
    chk({tag, ".err_timeout"},    err_timeout,    err_exp);
  endtask

  // One complete frame with per-cycle checks against a cycle-count model:
  // cycle k counts from the edge that accepted start; the pipe is live from
  // cycle RC+1 until the frame ends; the frame ends the cycle after both
  // counts were already met (or after TO beat-free live cycles).
  task automatic frame(input string tag, input int ci, input int co,
                       input int p_in, input int p_pr, input int p_ov, input int p_or,
                       input int restart_at);
    int cyc;
    int done_cyc;
    bit act, adm, oen, ib, ob, to_flag;
    logic [127:0] m;
`ifdef PIPE_FRAME_CTRL_TIMEOUT_EN
    int idle;
    idle = 0;
`endif
    m = {$urandom, $urandom, $urandom, $urandom};
    rand_inputs(p_in, p_pr, p_ov, p_or);
    start = 1'b1;
    cfg_in_tokens = ci;
    cfg_out_tokens = co;
    mmio_in = m;
    check_idle({tag, ".prestart"});
    tick();
    mmio_exp = m;
    in_exp = 0;
    out_exp = 0;
    err_exp = 1'b0;
    cyc = 1;
    done_cyc = -1;
    to_flag = 1'b0;
    while (1) begin
      rand_inputs(p_in, p_pr, p_ov, p_or);
      start = (cyc == restart_at);
      #1;
      act = (cyc >= RC + 1) && (done_cyc < 0);
      adm = act && (in_exp < ci);
      oen = act && (out_exp < co);
      if (cyc == done_cyc && to_flag) err_exp = 1'b1;
      chk({tag, ".pipe_in_valid"},  pipe_in_valid,  in_valid && adm);
      chk({tag, ".in_ready"},       in_ready,       pipe_in_ready && adm);
      chk({tag, ".out_valid"},      out_valid,      pipe_out_valid && oen);
      chk({tag, ".pipe_out_ready"}, pipe_out_ready, out_ready && oen);
      chk({tag, ".pipe_reset"},     pipe_reset,     !act);
      chk({tag, ".busy"},           busy,           cyc != done_cyc);
      chk({tag, ".done"},           done,           cyc == done_cyc);
      chk({tag, ".in_count"},       in_count,       in_exp);
      chk({tag, ".out_count"},      out_count,      out_exp);
      chk({tag, ".mmio_lat"},       mmio_lat,       mmio_exp);
      chk({tag, ".err_timeout"},    err_timeout,    err_exp);
      if (cyc == done_cyc) break;
      ib = in_valid && pipe_in_ready && adm;
      ob = pipe_out_valid && out_ready && oen;
      if (act && in_exp == ci && out_exp == co) begin
        done_cyc = cyc + 1;
      end
`ifdef PIPE_FRAME_CTRL_TIMEOUT_EN
      else if (act) begin
        idle = (ib || ob) ? 0 : idle + 1;
        if (idle == TO) begin
          done_cyc = cyc + 1;
          to_flag = 1'b1;
        end
      end
`endif
      in_exp += int'(ib);
      out_exp += int'(ob);
      if (cyc > 4000) begin
        checks++;
        errors++;
        $display("FAIL %s frame end not reached within cycle budget (in_count=%0d out_count=%0d)",
                 tag, in_count, out_count);
        break;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    tick();
    rand_inputs(p_in, p_pr, p_ov, p_or);
    check_idle({tag, ".after"});
    $display("frame %s cfg_in=%0d cfg_out=%0d in=%0d out=%0d end_cycle=%0d", tag, ci, co,
             in_exp, out_exp, done_cyc);
  endtask

  initial begin
    // Reset held, then idle with no start: pipe stays in reset, gates closed.
    repeat (3) begin
      tick();
      rand_inputs(80, 80, 80, 80);
      check_idle("reset");
    end
    reset = 1'b0;
    repeat (10) begin
      tick();
      rand_inputs(80, 80, 80, 80);
      check_idle("idle");
    end
    $display("idle phase done");

    frame("basic", 16, 8, 70, 70, 70, 70, -1);
    frame("overoffer", 16, 4, 100, 100, 60, 80, -1);
    frame("restart", 12, 12, 60, 60, 60, 60, RC + 3);
    frame("restart_flush", 6, 6, 60, 60, 60, 60, 2);
    frame("zero", 0, 0, 50, 50, 50, 50, -1);
    frame("outzero", 5, 0, 70, 70, 70, 70, -1);
    frame("inzero", 0, 6, 70, 70, 70, 70, -1);
    frame("full_rate", 10, 10, 100, 100, 100, 100, -1);
    for (int i = 0; i < 6; i++) begin
      frame($sformatf("rand%0d", i), $urandom_range(0, 20), $urandom_range(0, 20),
            $urandom_range(30, 100), $urandom_range(30, 100),
            $urandom_range(30, 100), $urandom_range(30, 100), -1);
    end

`ifdef PIPE_FRAME_CTRL_TIMEOUT_EN
    frame("timeout", 0, 5, 50, 50, 0, 50, -1);
    frame("after_timeout", 3, 3, 80, 80, 80, 80, -1);
`endif

    // Reset in the middle of a frame discards everything.
    tick();
    start = 1'b1;
    cfg_in_tokens = 10;
    cfg_out_tokens = 10;
    mmio_in = {$urandom, $urandom, $urandom, $urandom};
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    pipe_in_ready = 1'b1;
    pipe_out_valid = 1'b1;
    out_ready = 1'b1;
    repeat (RC + 3) tick();
    #1;
    chk("midreset.in_count_before", in_count, 3);
    chk("midreset.out_count_before", out_count, 3);
    chk("midreset.busy_before", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_exp = 0;
    out_exp = 0;
    mmio_exp = '0;
    err_exp = 1'b0;
    check_idle("midreset");
    $display("mid-frame reset done");
    frame("post_reset", 7, 9, 70, 70, 70, 70, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

endmodule
